rca_acc_32bit: RTL and testbench

RCA_ACC_32BIT -- requirements
Module: rca_acc_32bit

---
 rtl/rca_pkg.sv | 21 ++
 rtl/rca_32bit.sv | 24 ++
 rtl/rca_acc_32bit.sv | 115 +++++++++++
 tb/tb_rca_acc_32bit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared encodings for the ripple-carry accumulator: data width, opcodes, FSM states.
// Also holds the registered command type passed from the handshake stage into execution.
package rca_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] dat;
  } cmd_t;

endpackage

// File: rtl/rca_32bit.sv
// Combinational 32-bit ripple-carry adder built from explicit full-adder cells.
// Zero latency, no flow control; carry_start feeds bit 0 so SUB can add ~b + 1.
module rca_32bit
  import rca_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carry_start,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  logic [DATA_W:0] c;

  assign c[0] = carry_start;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fa
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign carry = c[DATA_W];

endmodule

// File: rtl/rca_acc_32bit.sv
// Accumulator with ADD/SUB/LOAD/CLEAR over a ripple-carry adder; one command in flight.
// Accept at edge N -> out_valid after N+2; result held in RESP until out_ready; in_ready only in IDLE.
module rca_acc_32bit
  import rca_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic              ovf,
  output logic [CNT_W-1:0]  op_count
);

  logic [1:0]        state;
  logic              exec_ph;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic [DATA_W-1:0] sum_q;
  logic              cout_q;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_RESP);

  // SUB is acc + ~operand + 1; carry-out of 0 then means a borrow occurred.
  always_comb begin
    add_b   = cmd_q.dat;
    add_cin = 1'b0;
    if (cmd_q.op == OP_SUB) begin
      add_b   = ~cmd_q.dat;
      add_cin = 1'b1;
    end
  end

  rca_32bit u_rca (
    .a           (acc),
    .b           (add_b),
    .carry_start (add_cin),
    .sum         (add_sum),
    .carry       (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      exec_ph  <= 1'b0;
      cmd_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      acc      <= '0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cmd_q.op  <= in_op;
            cmd_q.dat <= in_data;
            exec_ph   <= 1'b0;
            state     <= ST_EXEC;
            if (in_op == OP_CLEAR) op_count <= '0;
            else                   op_count <= op_count + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          // First EXEC cycle gives the ripple chain a full period; the second commits.
          if (!exec_ph) begin
            sum_q   <= add_sum;
            cout_q  <= add_cout;
            exec_ph <= 1'b1;
          end else begin
            state <= ST_RESP;
            case (cmd_q.op)
              OP_ADD: begin
                acc   <= sum_q;
                carry <= cout_q;
                if (cout_q) ovf <= 1'b1;
              end
              OP_SUB: begin
                acc   <= sum_q;
                carry <= cout_q;
                if (!cout_q) ovf <= 1'b1;
              end
              OP_LOAD: begin
                acc   <= cmd_q.dat;
                carry <= 1'b0;
              end
              default: begin
                acc   <= '0;
                carry <= 1'b0;
                ovf   <= 1'b0;
              end
            endcase
          end
        end
        ST_RESP: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_acc_32bit.sv
// Directed bench for rca_acc_32bit: arithmetic reference model, per-cycle compare in RESP,
// plus literal expectations for the documented scenarios.
module tb_rca_acc_32bit;

  localparam int CNT_W = 8;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      acc;
  logic             carry;
  logic             ovf;
  logic [CNT_W-1:0] op_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0]      m_acc;
  logic             m_carry;
  logic             m_ovf;
  logic [CNT_W-1:0] m_cnt;

  rca_acc_32bit #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .carry     (carry),
    .ovf       (ovf),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = '0; m_carry = 1'b0; m_ovf = 1'b0; m_cnt = '0;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [31:0] d);
    logic [32:0] wide;
    case (op)
      ADD: begin
        wide    = {1'b0, m_acc} + {1'b0, d};
        m_acc   = wide[31:0];
        m_carry = wide[32];
        if (m_carry) m_ovf = 1'b1;
        m_cnt   = m_cnt + 1'b1;
      end
      SUB: begin
        m_carry = (m_acc >= d);
        m_acc   = m_acc - d;
        if (!m_carry) m_ovf = 1'b1;
        m_cnt   = m_cnt + 1'b1;
      end
      LOAD: begin
        m_acc = d; m_carry = 1'b0; m_cnt = m_cnt + 1'b1;
      end
      default: begin
        m_acc = '0; m_carry = 1'b0; m_ovf = 1'b0; m_cnt = '0;
      end
    endcase
  endtask

  // Every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      chk("cmp_acc",   acc,            m_acc);
      chk("cmp_carry", 32'(carry),     32'(m_carry));
      chk("cmp_ovf",   32'(ovf),       32'(m_ovf));
      chk("cmp_cnt",   32'(op_count),  32'(m_cnt));
    end
  end

  // Returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) chk("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_apply(op, d);
  endtask

  // Called right after acceptance edge N; returns at N+2+#1 with the result showing.
  task automatic wait_res();
    @(posedge clk); #1;
    chk("lat_n1_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_n2_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; in_op = ADD; in_data = '0; out_ready = 1'b1;
    model_reset();
    #12;
    chk("rst_acc",       acc,             32'h0);
    chk("rst_carry",     32'(carry),      32'd0);
    chk("rst_ovf",       32'(ovf),        32'd0);
    chk("rst_cnt",       32'(op_count),   32'd0);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_in_ready",  32'(in_ready),   32'd1);
    @(negedge clk); rst_n = 1'b1;

    // LOAD 5, ADD 3
    send(LOAD, 32'h5); wait_res();
    send(ADD, 32'h3);  wait_res();
    chk("r30_acc",   acc,           32'h8);
    chk("r30_carry", 32'(carry),    32'd0);
    chk("r30_ovf",   32'(ovf),      32'd0);
    chk("r30_cnt",   32'(op_count), 32'd2);

    // Consumer stalls; a command offered meanwhile must be dropped
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        @(negedge clk);
        in_valid = 1'b1; in_op = ADD; in_data = 32'h10;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      chk("stall_acc",       acc,            32'h8);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", 32'(out_valid), 32'd0);
    chk("stall_cnt",           32'(op_count),  32'd2);
    chk("stall_acc_after",     acc,            32'h8);

    // Wrap on ADD, carry clears on next non-overflowing ADD, ovf sticky
    do_reset();
    send(LOAD, 32'hFFFF_FFFF); wait_res();
    send(ADD, 32'h1); wait_res();
    chk("r31_acc",   acc,        32'h0);
    chk("r31_carry", 32'(carry), 32'd1);
    chk("r31_ovf",   32'(ovf),   32'd1);
    send(ADD, 32'h1); wait_res();
    chk("r31b_acc",   acc,        32'h1);
    chk("r31b_carry", 32'(carry), 32'd0);
    chk("r31b_ovf",   32'(ovf),   32'd1);

    // SUB without borrow, then with borrow, then CLEAR
    do_reset();
    send(LOAD, 32'd10); wait_res();
    send(SUB, 32'd3);   wait_res();
    chk("sub_nb_acc",   acc,        32'h7);
    chk("sub_nb_carry", 32'(carry), 32'd1);
    chk("sub_nb_ovf",   32'(ovf),   32'd0);
    send(LOAD, 32'h3); wait_res();
    send(SUB, 32'h5);  wait_res();
    chk("r32_acc",   acc,        32'hFFFF_FFFE);
    chk("r32_carry", 32'(carry), 32'd0);
    chk("r32_ovf",   32'(ovf),   32'd1);
    send(CLR, 32'hDEAD_BEEF); wait_res();
    chk("r32_clr_acc", acc,           32'h0);
    chk("r32_clr_ovf", 32'(ovf),      32'd0);
    chk("r32_clr_cnt", 32'(op_count), 32'd0);

    // Reset while ADD 7 is executing
    do_reset();
    send(LOAD, 32'h1); wait_res();
    send(ADD, 32'h7);
    #2 rst_n = 1'b0;
    #1;
    chk("r34_acc",       acc,            32'h0);
    chk("r34_carry",     32'(carry),     32'd0);
    chk("r34_ovf",       32'(ovf),       32'd0);
    chk("r34_cnt",       32'(op_count),  32'd0);
    chk("r34_out_valid", 32'(out_valid), 32'd0);
    chk("r34_in_ready",  32'(in_ready),  32'd1);
    model_reset();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("r34_no_result", 32'(seen), 32'd0);
    send(LOAD, 32'h2); wait_res();
    chk("r34_load_acc", acc,           32'h2);
    chk("r34_load_cnt", 32'(op_count), 32'd1);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 257; i++) begin
      send(LOAD, 32'(i)); wait_res();
    end
    chk("r35_cnt", 32'(op_count), 32'h01);
    chk("r35_ovf", 32'(ovf),      32'd0);
    chk("r35_acc", acc,           32'd256);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
